lap_reader: RTL and testbench

Read-side controller for the stopwatch lap memory. The counter block writes 8-bit lap/pause snapshots into a single-port synchronous memory. `lap_reader` is the other end of that memory: on operator request it fetches stored entries one at a time and presents them to the display path, wrapping over the valid entries. It owns the memory read port, and the counter owns the write port.

---
 rtl/lap_reader.sv | 134 +++++++++++++
 tb/tb_lap_reader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lap_reader.sv
// lap_reader: read-side controller for the stopwatch lap memory.
// Fetches one stored lap/pause snapshot per rising edge of the step button,
// walking addresses 0..lap_count-1 and wrapping back to 0. The memory read
// port is synchronous, so every fetch is ISSUE (strobe + address) followed by
// WAIT (data returns) before the word is shown.
module lap_reader #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] lap_count,
   input  logic                  step,
   input  logic                  rewind,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,
   output logic [DATA_WIDTH-1:0] lap_value,
   output logic [ADDR_WIDTH-1:0] lap_index,
   output logic                  lap_valid,
   output logic                  busy,
   output logic                  empty
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      SHOW  = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [ADDR_WIDTH-1:0]   lap_index_q, lap_index_d;
   logic [DATA_WIDTH-1:0]   lap_value_q, lap_value_d;
   logic                    lap_valid_q, lap_valid_d;
   logic                    step_q;

   logic                    step_rise;
   logic                    count_zero;
   logic [ADDR_WIDTH-1:0]   eff_addr;
   logic [ADDR_WIDTH:0]     next_ptr;
   logic                    ptr_wraps;

   // Edge detect, empty flag, clamped read address and wrap-around pointer math.
   // The pointer advance is one bit wider so eff+1 can never alias with 0.
   always_comb begin
      step_rise  = step & ~step_q;
      count_zero = (lap_count == '0);
      eff_addr   = (rd_ptr_q < lap_count) ? rd_ptr_q : '0;
      next_ptr   = {1'b0, lap_index_q} + {{ADDR_WIDTH{1'b0}}, 1'b1};
      ptr_wraps  = (next_ptr == {1'b0, lap_count});
   end

   // Next-state logic: rewind overrides everything, otherwise the fetch walks
   // IDLE/SHOW -> ISSUE -> WAIT -> SHOW; step edges during a fetch are dropped.
   always_comb begin
      state_d     = state_q;
      rd_ptr_d    = rd_ptr_q;
      lap_index_d = lap_index_q;
      lap_value_d = lap_value_q;
      lap_valid_d = lap_valid_q;
      addr_d      = (state_q == ISSUE) ? eff_addr : addr_q;

      if (rewind) begin
         rd_ptr_d    = '0;
         lap_valid_d = 1'b0;
         state_d     = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (step_rise && !count_zero) begin
                  state_d = ISSUE;
               end
            end
            ISSUE: begin
               lap_index_d = eff_addr;
               state_d     = WAIT;
            end
            WAIT: begin
               lap_value_d = mem_rd_data;
               lap_valid_d = 1'b1;
               rd_ptr_d    = ptr_wraps ? '0 : next_ptr[ADDR_WIDTH-1:0];
               state_d     = SHOW;
            end
            SHOW: begin
               if (count_zero) begin
                  lap_valid_d = 1'b0;
                  state_d     = IDLE;
               end else if (step_rise) begin
                  state_d = ISSUE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and datapath registers; reset clears the display immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         rd_ptr_q    <= '0;
         addr_q      <= '0;
         lap_index_q <= '0;
         lap_value_q <= '0;
         lap_valid_q <= 1'b0;
         step_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_ptr_q    <= rd_ptr_d;
         addr_q      <= addr_d;
         lap_index_q <= lap_index_d;
         lap_value_q <= lap_value_d;
         lap_valid_q <= lap_valid_d;
         step_q      <= step;
      end
   end

   // Memory strobe only in ISSUE; the address holds its last issued value otherwise.
   always_comb begin
      mem_rd_en = (state_q == ISSUE);
      mem_addr  = (state_q == ISSUE) ? eff_addr : addr_q;
      busy      = (state_q == ISSUE) || (state_q == WAIT);
      empty     = count_zero;
      lap_value = lap_value_q;
      lap_index = lap_index_q;
      lap_valid = lap_valid_q;
   end

endmodule

// File: tb/tb_lap_reader.sv
// tb_lap_reader: scoreboard bench for lap_reader with a synchronous memory model.
module tb_lap_reader;

   logic       clk;
   logic       rst;
   logic [7:0] lap_count;
   logic       step;
   logic       rewind;
   logic       mem_rd_en;
   logic [7:0] mem_addr;
   logic [7:0] mem_rd_data;
   logic [7:0] lap_value;
   logic [7:0] lap_index;
   logic       lap_valid;
   logic       busy;
   logic       empty;

   logic [7:0] mem [0:255];

   typedef struct packed {
      logic [7:0] idx;
      logic [7:0] val;
   } exp_t;

   exp_t expQ[$];
   int   testsRun    = 0;
   int   testsFailed = 0;
   int   rdEnCount   = 0;
   int   baseCount;

   lap_reader #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .lap_count   (lap_count),
      .step        (step),
      .rewind      (rewind),
      .mem_rd_en   (mem_rd_en),
      .mem_addr    (mem_addr),
      .mem_rd_data (mem_rd_data),
      .lap_value   (lap_value),
      .lap_index   (lap_index),
      .lap_valid   (lap_valid),
      .busy        (busy),
      .empty       (empty)
   );

   // Free-running clock, 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous-read memory: data appears the edge after the strobe.
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
      mem[0] = 8'h11;
      mem[1] = 8'h22;
      mem[2] = 8'h33;
      mem_rd_data = 8'h00;
   end

   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= mem[mem_addr];
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Monitor: a fetch completes when busy drops with lap_valid set; compare it
   // against the oldest expected entry.
   initial begin : monitor
      logic prevBusy;
      exp_t e;
      prevBusy = 1'b0;
      forever begin
         @(negedge clk);
         if (mem_rd_en === 1'b1) rdEnCount++;
         if (prevBusy && !busy && lap_valid) begin
            if (expQ.size() == 0) begin
               testsRun++;
               testsFailed++;
               $display("[TB] FAIL unexpectedFetch: got index %0h value %0h, expected no fetch", lap_index, lap_value);
            end else begin
               e = expQ.pop_front();
               checkOutput("fetchIndex", {24'd0, lap_index}, {24'd0, e.idx});
               checkOutput("fetchValue", {24'd0, lap_value}, {24'd0, e.val});
            end
         end
         prevBusy = busy;
      end
   end

   // One full fetch with cycle-exact timing checks; the value is left to the monitor.
   task automatic applyStimulus(input logic [7:0] expIdx, input logic [7:0] expVal);
      expQ.push_back('{idx: expIdx, val: expVal});
      step = 1'b1;
      @(posedge clk); #1;
      step = 1'b0;
      checkOutput("issueRdEn", {31'd0, mem_rd_en}, 32'd1);
      checkOutput("issueBusy", {31'd0, busy}, 32'd1);
      checkOutput("issueAddr", {24'd0, mem_addr}, {24'd0, expIdx});
      @(posedge clk); #1;
      checkOutput("waitRdEn", {31'd0, mem_rd_en}, 32'd0);
      checkOutput("waitBusy", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      checkOutput("showBusy", {31'd0, busy}, 32'd0);
      checkOutput("showValid", {31'd0, lap_valid}, 32'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1;
      step = 1'b0;
      rewind = 1'b0;
      lap_count = 8'd0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("resetRdEn", {31'd0, mem_rd_en}, 32'd0);
      checkOutput("resetAddr", {24'd0, mem_addr}, 32'd0);
      checkOutput("resetValue", {24'd0, lap_value}, 32'd0);
      checkOutput("resetIndex", {24'd0, lap_index}, 32'd0);
      checkOutput("resetValid", {31'd0, lap_valid}, 32'd0);
      checkOutput("resetBusy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Empty memory: step must not start a read.
      step = 1'b1;
      @(posedge clk); #1;
      step = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checkOutput("emptyRdEnCount", rdEnCount, 32'd0);
      checkOutput("emptyFlag", {31'd0, empty}, 32'd1);
      checkOutput("emptyValid", {31'd0, lap_valid}, 32'd0);
      checkOutput("emptyBusy", {31'd0, busy}, 32'd0);

      // Sequential read with wrap over three entries.
      lap_count = 8'd3;
      @(posedge clk); #1;
      checkOutput("notEmpty", {31'd0, empty}, 32'd0);
      applyStimulus(8'd0, 8'h11);
      applyStimulus(8'd1, 8'h22);
      applyStimulus(8'd2, 8'h33);
      applyStimulus(8'd0, 8'h11);
      checkOutput("wrapRdEnCount", rdEnCount, 32'd4);

      // Held step: exactly one fetch.
      baseCount = rdEnCount;
      expQ.push_back('{idx: 8'd1, val: 8'h22});
      step = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      step = 1'b0;
      @(posedge clk); #1;
      checkOutput("heldRdEnCount", rdEnCount, baseCount + 1);

      // Second rising edge inside the busy window is dropped.
      baseCount = rdEnCount;
      expQ.push_back('{idx: 8'd2, val: 8'h33});
      step = 1'b1;
      @(posedge clk); #1;
      step = 1'b0;
      @(posedge clk); #1;
      step = 1'b1;
      @(posedge clk); #1;
      step = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("droppedRdEnCount", rdEnCount, baseCount + 1);
      checkOutput("droppedBusy", {31'd0, busy}, 32'd0);

      // Rewind the cycle after the strobe: data discarded, restart at 0.
      applyStimulus(8'd0, 8'h11);
      step = 1'b1;
      @(posedge clk); #1;
      step = 1'b0;
      @(posedge clk); #1;
      rewind = 1'b1;
      @(posedge clk); #1;
      rewind = 1'b0;
      checkOutput("rewindValid", {31'd0, lap_valid}, 32'd0);
      checkOutput("rewindBusy", {31'd0, busy}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rewindValidHeld", {31'd0, lap_valid}, 32'd0);
      applyStimulus(8'd0, 8'h11);

      // Shrinking count: display is kept, next fetch wraps/clamps to 0.
      applyStimulus(8'd1, 8'h22);
      applyStimulus(8'd2, 8'h33);
      lap_count = 8'd2;
      @(posedge clk); #1;
      checkOutput("shrinkHeldValue", {24'd0, lap_value}, 32'h33);
      checkOutput("shrinkHeldIndex", {24'd0, lap_index}, 32'd2);
      checkOutput("shrinkHeldValid", {31'd0, lap_valid}, 32'd1);
      applyStimulus(8'd0, 8'h11);
      lap_count = 8'd3;
      applyStimulus(8'd1, 8'h22);
      lap_count = 8'd2;
      @(posedge clk); #1;
      checkOutput("clampHeldIndex", {24'd0, lap_index}, 32'd1);
      applyStimulus(8'd0, 8'h11);

      // Reset asserted mid-read clears outputs without waiting for an edge.
      step = 1'b1;
      @(posedge clk); #1;
      step = 1'b0;
      checkOutput("midReadRdEn", {31'd0, mem_rd_en}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("asyncRdEn", {31'd0, mem_rd_en}, 32'd0);
      checkOutput("asyncAddr", {24'd0, mem_addr}, 32'd0);
      checkOutput("asyncValue", {24'd0, lap_value}, 32'd0);
      checkOutput("asyncIndex", {24'd0, lap_index}, 32'd0);
      checkOutput("asyncValid", {31'd0, lap_valid}, 32'd0);
      checkOutput("asyncBusy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      applyStimulus(8'd0, 8'h11);

      // Count dropping to zero while showing clears the display.
      lap_count = 8'd0;
      @(posedge clk); #1;
      checkOutput("zeroCountValid", {31'd0, lap_valid}, 32'd0);
      checkOutput("zeroCountEmpty", {31'd0, empty}, 32'd1);
      step = 1'b1;
      @(posedge clk); #1;
      step = 1'b0;
      checkOutput("zeroCountRdEn", {31'd0, mem_rd_en}, 32'd0);
      checkOutput("zeroCountBusy", {31'd0, busy}, 32'd0);

      repeat (3) @(posedge clk);
      #1;
      checkOutput("queueDrained", expQ.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
